// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
// mul_pkg : shared types and constants for the sequential signed multiplier
// Rev 1.0
// ============================================================================
package mul_pkg;

    localparam int WIDTH      = 32;
    localparam int MUL_CYCLES = 32;
    localparam int CNT_W      = 5;

    localparam logic [WIDTH-1:0] INT_MAX_MAG = 32'h7FFF_FFFF;
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(MUL_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ABS_A = 3'd1,
        ABS_B = 3'd2,
        MUL   = 3'd3,
        FIX   = 3'd4,
        DONE  = 3'd5
    } mul_state_e;

endpackage : mul_pkg
`default_nettype wire

// File: rtl/twoscomplement.sv
`default_nettype none
// ============================================================================
// twoscomplement : 32-bit two's-complement negator
// Rev 1.0
// ============================================================================
module twoscomplement (
    input  logic [31:0] value_i,
    output logic [31:0] neg_o
);

    assign neg_o = ~value_i + 32'd1;

endmodule : twoscomplement
`default_nettype wire

// File: rtl/seq_signed_mult.sv
`default_nettype none
// ============================================================================
// seq_signed_mult : 32x32 signed multiplier, sign-magnitude shift-add around
//                   one shared negator. Rev 1.0
// ============================================================================
module seq_signed_mult
    import mul_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             ovf
);

    mul_state_e         state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               sign_q;
    logic [WIDTH-1:0]   mag_a_q;
    logic [WIDTH-1:0]   mag_b_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   product_q;
    logic               ovf_q;
    logic               busy_q;
    logic               done_q;

    logic [WIDTH-1:0]   neg_in_d;
    logic [WIDTH-1:0]   neg_out;
    logic [2*WIDTH-1:0] addend_d;
    logic               ovf_d;

    // Negator input depends only on the state, so it is idle-quiet outside the sign steps
    always_comb begin
        neg_in_d = '0;
        case (state_q)
            ABS_A:   neg_in_d = a_q;
            ABS_B:   neg_in_d = b_q;
            FIX:     neg_in_d = acc_q[WIDTH-1:0];
            default: neg_in_d = '0;
        endcase
    end

    twoscomplement u_neg (
        .value_i (neg_in_d),
        .neg_o   (neg_out)
    );

    assign addend_d = {{WIDTH{1'b0}}, mag_a_q} << cnt_q;

    // A negative result may reach magnitude 2^31; a positive one only 2^31-1
    assign ovf_d = sign_q ? (acc_q > ({{WIDTH{1'b0}}, INT_MAX_MAG} + 64'd1))
                          : (acc_q >  {{WIDTH{1'b0}}, INT_MAX_MAG});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sign_q    <= 1'b0;
            mag_a_q   <= '0;
            mag_b_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        sign_q  <= a[WIDTH-1] ^ b[WIDTH-1];
                        busy_q  <= 1'b1;
                        state_q <= ABS_A;
                    end
                end
                ABS_A: begin
                    mag_a_q <= a_q[WIDTH-1] ? neg_out : a_q;
                    state_q <= ABS_B;
                end
                ABS_B: begin
                    mag_b_q <= b_q[WIDTH-1] ? neg_out : b_q;
                    acc_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= MUL;
                end
                MUL: begin
                    if (mag_b_q[0]) begin
                        acc_q <= acc_q + addend_d;
                    end
                    mag_b_q <= mag_b_q >> 1;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    product_q <= sign_q ? neg_out : acc_q[WIDTH-1:0];
                    ovf_q     <= ovf_d;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b1;
                    state_q   <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;
    assign ovf     = ovf_q;

endmodule : seq_signed_mult
`default_nettype wire

// File: tb/tb_seq_signed_mult.sv
`default_nettype none
// ============================================================================
// tb_seq_signed_mult : directed self-checking bench for seq_signed_mult
// Rev 1.0
// ============================================================================
module tb_seq_signed_mult;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] product;
    logic        ovf;

    int          n_checks;
    int          n_fail;
    logic [31:0] last_p;
    logic        last_o;

    seq_signed_mult dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Runs one operation; optionally pulses start with other operands mid-MUL
    task automatic do_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                         input logic [31:0] ep, input logic eo, input bit inject);
        int k;
        int busy_cnt;
        @(negedge clk);
        start = 1'b1;
        a     = ta;
        b     = tb_v;
        @(posedge clk);
        #1;
        start    = 1'b0;
        k        = 0;
        busy_cnt = 0;
        while (k < 60 && !done) begin
            if (busy) busy_cnt++;
            if (k == 10) begin
                check({tag, "_held_p"}, {32'd0, product}, {32'd0, last_p});
                check({tag, "_held_o"}, {63'd0, ovf}, {63'd0, last_o});
            end
            if (inject && k == 10) begin
                start = 1'b1;
                a     = 32'd5;
                b     = 32'd5;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            k++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 64'(k), 64'd35);
        check({tag, "_busycnt"}, 64'(busy_cnt), 64'd35);
        check({tag, "_product"}, {32'd0, product}, {32'd0, ep});
        check({tag, "_ovf"}, {63'd0, ovf}, {63'd0, eo});
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
        last_p = ep;
        last_o = eo;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        last_p   = 32'd0;
        last_o   = 1'b0;
        rst_n    = 1'b0;
        start    = 1'b0;
        a        = 32'd0;
        b        = 32'd0;
        #12;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_product", {32'd0, product}, 64'd0);
        check("rst_ovf", {63'd0, ovf}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("basic",   32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 1'b0);
        do_op("min_x1",  32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0, 1'b0);
        do_op("min_xm1", 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0);
        do_op("pos_ovf", 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1, 1'b0);
        do_op("neg_lim", 32'hFFFF_0000,  32'h0000_8000, 32'h8000_0000, 1'b0, 1'b0);
        do_op("zero",    32'd0,          32'hFFFF_FFFB, 32'h0000_0000, 1'b0, 1'b0);
        do_op("negneg",  32'hFFFF_FFFB,  32'hFFFF_FFFA, 32'h0000_001E, 1'b0, 1'b0);
        do_op("inject",  32'h0000_007B,  32'hFFFF_FFFE, 32'hFFFF_FF0A, 1'b0, 1'b1);
        do_op("b2b",     32'h7FFF_FFFF,  32'd2,         32'hFFFF_FFFE, 1'b1, 1'b0);

        // Asynchronous reset in the middle of MUL
        @(negedge clk);
        start = 1'b1;
        a     = 32'd5;
        b     = 32'd6;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {63'd0, busy}, 64'd0);
        check("arst_done", {63'd0, done}, 64'd0);
        check("arst_product", {32'd0, product}, 64'd0);
        check("arst_ovf", {63'd0, ovf}, 64'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        last_p = 32'd0;
        last_o = 1'b0;
        do_op("post_rst", 32'd3, 32'd4, 32'd12, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_seq_signed_mult
`default_nettype wire

// File: doc/seq_signed_mult.md
Name: seq_signed_mult

Overview:
- Multi-cycle 32x32 signed multiplier controller built around one shared instance of the existing 32-bit negation unit `twoscomplement`.
- Sequences the negator to form operand magnitudes, runs a 32-iteration shift-add on the magnitudes, then negates the result when the signs differ.
- Sits beside the ALU as the MUL execution resource. One operation in flight; start/busy/done handshake.

Parameters:
- WIDTH, 32, operand/result width. Only 32 is supported because the shared negator is fixed at 32 bits.
- MUL_CYCLES, 32, shift-add iterations. Equals WIDTH.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request. Sampled only in IDLE.
- a  in  32  signed multiplicand. Captured when start is accepted.
- b  in  32  signed multiplier. Captured when start is accepted.
- busy  out  1  high from the cycle after start is accepted through the FIX state.
- done  out  1  single-cycle pulse; result valid.
- product  out  32  low 32 bits of the signed product. Held until the next accepted start.
- ovf  out  1  signed result outside [-2^31, 2^31-1]. Held with product.

Behaviour:
- Reset (rst_n low, any state, including mid-operation): state=IDLE; busy=0, done=0, product=0, ovf=0; internal registers cleared. Takes effect immediately, no clock needed.
- States and transitions:
  - IDLE: start=1 -> capture a, b; sign_r = a[31]^b[31]; go to ABS_A.
  - ABS_A: negator input = a_r. mag_a = a_r[31] ? neg : a_r. Go to ABS_B.
  - ABS_B: negator input = b_r. mag_b = b_r[31] ? neg : b_r. Clear 64-bit acc. Go to MUL.
  - MUL, 32 cycles, 5-bit counter 0..31:
    - if mag_b[0]: acc = acc + (mag_a << cnt), 64-bit unsigned add.
    - mag_b >>= 1 each cycle.
    - Leave MUL after cnt==31.
  - FIX:
    - negator input = acc[31:0].
    - product <= sign_r ? neg : acc[31:0].
    - Overflow: ovf <= sign_r ? (acc > 2^31) : (acc > 2^31-1).
    - Go to DONE.
  - DONE: done=1 for one cycle; busy=0; go to IDLE.
- Latency: start sampled at edge N -> done high in the cycle following edge N+35, i.e. 36 cycles from acceptance. Fixed and independent of data.
- start while busy or in DONE: ignored, no queueing. start in IDLE on the cycle after DONE is accepted normally.
- Negator input mux is a function of state only. It is driven with 0 in IDLE, MUL and DONE.
- Operand 0x80000000: negator returns 0x80000000. Treated as unsigned magnitude 2^31, which is correct.
- Zero result with sign_r=1: neg(0)=0, so product=0 and ovf=0.
- product and ovf change only in FIX. Otherwise they are stable, including while a new operation runs.

Decomposition:
- Shared package `mul_pkg`:
  - typedef enum for states: IDLE, ABS_A, ABS_B, MUL, FIX, DONE.
  - localparams WIDTH=32, MUL_CYCLES=32, CNT_W=5.
  - Constant INT_MAX_MAG = 2^31-1.
- Sub-modules: one instance of the existing `twoscomplement` as the negator. No other sub-module. FSM, counter and accumulator are inline.

Test Plan:
- Basic multiply: start with a=7, b=0xFFFFFFFD (-3) -> done exactly 36 cycles later; product=0xFFFFFFEB, ovf=0; busy high for 35 cycles.
- Most-negative operand:
  - a=0x80000000, b=1 -> product=0x80000000, ovf=0.
  - a=0x80000000, b=0xFFFFFFFF -> product=0x80000000, ovf=1.
- Overflow boundaries:
  - a=0x00010000, b=0x00010000 -> product=0x00000000, ovf=1.
  - a=0xFFFF0000, b=0x00008000 -> product=0x80000000, ovf=0.
- Zero result: a=0, b=0xFFFFFFFB -> product=0, ovf=0.
- start pulsed during MUL with different operands -> ignored; first result unchanged and done fires once. Back-to-back start on the cycle after done -> accepted.
- rst_n low during MUL (cycle 20) -> busy=0, done=0, product=0, ovf=0 at once. After release, a new start=1, a=3, b=4 -> product=12, ovf=0.
